seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Controller that configures and sequences a programmable serial pattern detector over a bounded frame of input bits. It latches the pattern, length and overlap mode on start, then runs the detector for exactly frame_len valid bits. It emits per-match pulses and a saturating match count, and signals done at the end of the frame. It replaces per-pattern fixed detectors with one reusable, host-configured block.

Parameters:
PAT_W, 8, maximum pattern length in bits (1..15)
CNT_W, 8, match counter width
LEN_W, 16, frame length counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin a scan (honoured only in IDLE)
cfg_pat  in  PAT_W  pattern; cfg_pat[cfg_len-1] is the first bit received, cfg_pat[0] the last
cfg_len  in  4  pattern length in bits (valid range 1..PAT_W)
cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
frame_len  in  LEN_W  number of valid bits to scan (must be >0)
in_valid  in  1  serial bit qualifier
in  in  1  serial data bit
state  out  2  current FSM state
busy  out  1  high in LOAD or RUN
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  saturating count of matches in current/last frame
done  out  1  one-cycle pulse at end of frame
cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (async, rst=0): state=IDLE. All outputs 0. History, fill, bit counter and latched config cleared.
- State encoding: IDLE=0, LOAD=1, RUN=2, DONE=3.
- IDLE: start=1 with cfg_len==0, cfg_len>PAT_W, or frame_len==0 -> cfg_err=1 next cycle, stay IDLE. Otherwise latch cfg_* and frame_len, go to LOAD.
- LOAD (1 cycle): clear history, fill, bit counter and match_cnt -> RUN.
- RUN: each cycle with in_valid=1:
  - shift in into history LSB;
  - bit counter +1;
  - fill +1, saturating at PAT_W.
- Cycles with in_valid=0 change nothing.
- Match condition, evaluated on the updated history: fill >= cfg_len and history[cfg_len-1:0] == cfg_pat[cfg_len-1:0]. Bits of cfg_pat above cfg_len are ignored.
- Match response: match=1 on the cycle after the completing bit is sampled (registered, latency 1); match_cnt +1 on that same edge, saturating at 2^CNT_W-1.
- Non-overlap mode: on a match, fill resets to 0, so the next match needs cfg_len fresh bits. Overlap mode: fill unaffected.
- When the accepted bit is bit number frame_len: go to DONE. A match on that last bit still pulses match and is counted. Bits after it are not consumed.
- DONE (1 cycle): done=1 -> IDLE. match_cnt holds its value until the next LOAD.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- Config inputs are sampled only at accepted start; later changes have no effect mid-frame.
- Reset mid-frame aborts immediately: no done, count cleared.
- busy = (state==LOAD || state==RUN).

Decomposition:
- Shared package: state encodings IDLE/LOAD/RUN/DONE and a localparam for the cfg_len width (4).
- One sub-module, seq_match_core: history shift register, fill counter, compare and overlap clear. It takes shift/clear/cfg inputs and returns a match hit.
- FSM, bit counter, match counter and output registers stay in seq_scan_ctrl.

Test Plan:
- Overlap: pattern 3'b101, len 3, overlap=1, frame_len=5, stream 1,0,1,0,1 (in_valid=1 every cycle) -> match pulses after bits 3 and 5, match_cnt=2, done coincides with second match.
- Non-overlap: same config with overlap=0, same stream -> single match after bit 3, match_cnt=1, done after bit 5.
- Gaps and config errors:
  - in_valid gaps: stream 1,1,0,1 with in_valid deasserted 2 cycles between each bit, pattern 2'b01 len 2, frame 4 -> one match, after bit 4; timing is independent of gaps.
  - cfg_len=0 or frame_len=0 with start -> cfg_err pulse, state stays 0, busy=0.
- Saturation: CNT_W=2, pattern 1'b1 len 1, frame 6 of all ones -> 6 match pulses, match_cnt stops at 3.
- Reset mid-run: assert rst=0 after 2 of 5 bits -> immediate state=0, outputs 0, no done. A subsequent start with the same config runs cleanly from bit 1.

Source files
------------

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the programmable serial pattern scanner.
// Holds the controller state encoding and the width of the pattern-length
// field. Used by both seq_scan_ctrl and seq_match_core.
package seq_scan_ctrl_pkg;

  // Width of cfg_len. Four bits cover pattern lengths 1..15.
  localparam int CFG_LEN_W = 4;

  // The encoding is visible on the state output, so values are fixed.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_scan_ctrl_match_core.sv
// seq_match_core: history shift register, fill counter and pattern compare.
//
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   clear        zero history and fill (frame setup)
//   shift        accept bit_in this cycle
//   bit_in       serial data bit
//   cfg_pat      pattern; cfg_pat[cfg_len-1] is the oldest bit, cfg_pat[0] the newest
//   cfg_len      pattern length (1..PAT_W)
//   cfg_overlap  1 = overlapping matches, 0 = restart fill after each match
//   hit          combinational: the bit being shifted in completes a match
//
// hit is computed from the post-shift history and fill, so the parent can
// register it on the same edge that takes the bit in.
module seq_match_core
  import seq_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 bit_in,
  input  logic [PAT_W-1:0]     cfg_pat,
  input  logic [CFG_LEN_W-1:0] cfg_len,
  input  logic                 cfg_overlap,
  output logic                 hit
);

  localparam logic [CFG_LEN_W-1:0] FILL_MAX = CFG_LEN_W'(PAT_W);

  logic [PAT_W-1:0]     hist_q, hist_d;
  logic [PAT_W-1:0]     len_mask;
  logic [CFG_LEN_W-1:0] fill_q, fill_d;
  logic [CFG_LEN_W-1:0] fill_inc;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (CFG_LEN_W'(i) < cfg_len);
    end

    hist_d   = hist_q;
    fill_d   = fill_q;
    hit      = 1'b0;
    fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      // Shift form rather than a slice so PAT_W = 1 still elaborates.
      hist_d = (hist_q << 1) | PAT_W'(bit_in);
      // Pattern bits at or above cfg_len are masked out of the compare.
      hit    = (fill_inc >= cfg_len) && (((hist_d ^ cfg_pat) & len_mask) == '0);
      // Non-overlap: the next match must be built from entirely fresh bits.
      fill_d = (hit && !cfg_overlap) ? '0 : fill_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: host-configured serial pattern scanner over a bounded frame.
//
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   start        begin a scan (only acted on in IDLE)
//   cfg_pat      pattern, cfg_pat[cfg_len-1] received first
//   cfg_len      pattern length, 1..PAT_W
//   cfg_overlap  1 = overlapping matches
//   frame_len    number of valid bits to scan, > 0
//   in_valid/in  serial bit and qualifier (only consumed in RUN)
//   state        current FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   busy         high in LOAD or RUN
//   match        one-cycle pulse, one cycle after the completing bit
//   match_cnt    saturating match count for the current/last frame
//   done         one-cycle pulse at end of frame (the DONE cycle)
//   cfg_err      one-cycle pulse after a rejected start
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PAT_W-1:0]     cfg_pat,
  input  logic [CFG_LEN_W-1:0] cfg_len,
  input  logic                 cfg_overlap,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 in_valid,
  input  logic                 in,
  output logic [1:0]           state,
  output logic                 busy,
  output logic                 match,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [CFG_LEN_W-1:0] MAX_LEN = CFG_LEN_W'(PAT_W);

  state_t               state_q, state_d;
  logic [PAT_W-1:0]     pat_q, pat_d;
  logic [CFG_LEN_W-1:0] len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic [LEN_W-1:0]     frame_q, frame_d;
  logic [LEN_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]     bit_cnt_inc;
  logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
  logic                 match_q, match_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_bad;
  logic                 core_clear;
  logic                 core_shift;
  logic                 hit;

  assign core_clear = (state_q == S_LOAD);
  assign core_shift = (state_q == S_RUN) && in_valid;

  seq_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .clear       (core_clear),
    .shift       (core_shift),
    .bit_in      (in),
    .cfg_pat     (pat_q),
    .cfg_len     (len_q),
    .cfg_overlap (ovl_q),
    .hit         (hit)
  );

  always_comb begin
    cfg_bad     = (cfg_len == '0) || (cfg_len > MAX_LEN) || (frame_len == '0);
    bit_cnt_inc = bit_cnt_q + 1'b1;

    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    match_d     = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            pat_d   = cfg_pat;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            frame_d = frame_len;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        bit_cnt_d   = '0;
        match_cnt_d = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (in_valid) begin
          bit_cnt_d = bit_cnt_inc;
          match_d   = hit;
          if (hit && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
          // The last bit of the frame still reports its match alongside done.
          if (bit_cnt_inc == frame_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      match_q     <= match_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign state     = state_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl. Two instances share all inputs: one with an 8-bit
// match counter and one with a 2-bit counter to exercise saturation.
// Expected matches come from a frame-level model that scans the bit list for
// the pattern, restarting the eligible window after each match when overlap
// is off.
module tb_seq_scan_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] cfg_pat;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic             in_bit;

  logic [1:0] state_a, state_b;
  logic       busy_a, busy_b, match_a, match_b, done_a, done_b, err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic stim[0:63];
  int   exp_hit[0:64];
  int   exp_cum[0:64];

  always #5 clk = ~clk;

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(8), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .frame_len(frame_len), .in_valid(in_valid), .in(in_bit),
    .state(state_a), .busy(busy_a), .match(match_a), .match_cnt(cnt_a),
    .done(done_a), .cfg_err(err_a)
  );

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(2), .LEN_W(LEN_W)) u_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .frame_len(frame_len), .in_valid(in_valid), .in(in_bit),
    .state(state_b), .busy(busy_b), .match(match_b), .match_cnt(cnt_b),
    .done(done_b), .cfg_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Match at bit k (1-based) when at least len bits have arrived since the
  // window start and the last len bits, newest first, equal pat[0..len-1].
  task automatic build_model(input logic [7:0] pat, input int len, input logic ovl,
                             input int flen);
    int  seg_start;
    bit  ok;
    seg_start  = 0;
    exp_cum[0] = 0;
    for (int k = 1; k <= flen; k++) begin
      ok = ((k - seg_start) >= len);
      for (int j = 0; j < len; j++) begin
        if (ok && (stim[k-1-j] !== pat[j])) ok = 1'b0;
      end
      exp_hit[k] = ok ? 1 : 0;
      exp_cum[k] = exp_cum[k-1] + exp_hit[k];
      if (ok && !ovl) seg_start = k;
    end
  endtask

  task automatic scramble_inputs();
    start       = 1'($urandom);
    cfg_pat     = 8'($urandom);
    cfg_len     = 4'($urandom);
    cfg_overlap = 1'($urandom);
    frame_len   = 16'($urandom);
  endtask

  // Runs one complete frame from IDLE using stim[0..flen-1]; ends in IDLE at a
  // falling edge with start low.
  task automatic run_frame(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input int flen, input int gmin, input int gmax);
    int k;
    int gap;
    build_model(pat, int'(len), ovl, flen);

    cfg_pat = pat; cfg_len = len; cfg_overlap = ovl; frame_len = 16'(flen);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("load_state", state_a, 1);
    check("load_busy", busy_a, 1);
    check("load_err", err_a, 0);

    // Bits offered during LOAD must be ignored.
    scramble_inputs();
    in_valid = 1'b1; in_bit = 1'($urandom);
    @(negedge clk);
    check("run_state", state_a, 2);
    check("run_cnt_clr_a", cnt_a, 0);
    check("run_cnt_clr_b", cnt_b, 0);

    k = 0;
    while (k < flen) begin
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) begin
        scramble_inputs();
        in_valid = 1'b0; in_bit = 1'($urandom);
        @(negedge clk);
        check("gap_match", match_a, 0);
        check("gap_state", state_a, 2);
      end
      scramble_inputs();
      in_valid = 1'b1; in_bit = stim[k];
      @(negedge clk);
      k++;
      check("bit_match_a", match_a, exp_hit[k]);
      check("bit_match_b", match_b, exp_hit[k]);
      check("bit_cnt_a", cnt_a, sat(exp_cum[k], 255));
      check("bit_cnt_b", cnt_b, sat(exp_cum[k], 3));
      if (k < flen) begin
        check("mid_done", done_a, 0);
      end else begin
        check("end_state", state_a, 3);
        check("end_done_a", done_a, 1);
        check("end_done_b", done_b, 1);
        check("end_busy", busy_a, 0);
      end
    end

    // A bit after the frame is not consumed; the count holds.
    start = 1'b0; in_valid = 1'b1; in_bit = 1'($urandom);
    @(negedge clk);
    check("post_state", state_a, 0);
    check("post_done", done_a, 0);
    check("post_match", match_a, 0);
    check("post_cnt_a", cnt_a, sat(exp_cum[flen], 255));
    check("post_cnt_b", cnt_b, sat(exp_cum[flen], 3));
    in_valid = 1'b0;
  endtask

  task automatic cfg_reject(input string tag, input logic [3:0] len, input logic [15:0] flen);
    cfg_pat = 8'h5a; cfg_len = len; cfg_overlap = 1'b1; frame_len = flen;
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, err_a, 1);
    check({tag, "_state"}, state_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_err_clr"}, err_a, 0);
    check({tag, "_state2"}, state_a, 0);
  endtask

  task automatic load_stim(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) stim[i] = bits[n-1-i];
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
    frame_len = '0; in_valid = 1'b0; in_bit = 1'b0;
    for (int i = 0; i < 64; i++) stim[i] = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_state", state_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_match", match_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    rst = 1'b1;
    @(negedge clk);

    // Overlapping 101 in 10101: matches after bits 3 and 5.
    load_stim(8'b10101, 5);
    run_frame(8'b101, 4'd3, 1'b1, 5, 0, 0);
    check("ovl_total", cnt_a, 2);

    // Same stream without overlap: only bit 3 matches.
    run_frame(8'b101, 4'd3, 1'b0, 5, 0, 0);
    check("novl_total", cnt_a, 1);

    // Pattern 01 over 1,1,0,1 with two idle cycles before each bit.
    load_stim(8'b1101, 4);
    run_frame(8'b01, 4'd2, 1'b0, 4, 2, 2);
    check("gap_total", cnt_a, 1);

    cfg_reject("len0", 4'd0, 16'd5);
    cfg_reject("flen0", 4'd3, 16'd0);
    cfg_reject("len9", 4'd9, 16'd5);

    // Single-bit pattern over six ones: six pulses, 2-bit count stops at 3.
    load_stim(8'b111111, 6);
    run_frame(8'h01, 4'd1, 1'b1, 6, 0, 1);
    check("sat_total_a", cnt_a, 6);
    check("sat_total_b", cnt_b, 3);

    // Reset after two of five bits aborts at once.
    cfg_pat = 8'b101; cfg_len = 4'd3; cfg_overlap = 1'b1; frame_len = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    in_bit = 1'b0;
    @(negedge clk);
    in_bit = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("abort_state", state_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_match", match_a, 0);
    check("abort_cnt", cnt_a, 0);
    check("abort_done", done_a, 0);
    @(negedge clk);
    check("abort_done_hold", done_a, 0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    load_stim(8'b10101, 5);
    run_frame(8'b101, 4'd3, 1'b1, 5, 0, 0);
    check("rerun_total", cnt_a, 2);

    // Random frames; stream is biased toward repeats of the pattern.
    for (int f = 0; f < 25; f++) begin
      logic [7:0] pat;
      int         len;
      pat = 8'($urandom);
      len = $urandom_range(8, 1);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(3, 0) != 0) stim[i] = pat[len - 1 - (i % len)];
        else                           stim[i] = 1'($urandom);
      end
      run_frame(pat, 4'(len), 1'($urandom), $urandom_range(40, 1), 0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
